iccm_loader: RTL and testbench
==============================

ICCM_LOADER -- requirements
Module: iccm_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits; multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 14, word-address width.
REQ-003 SHALL have parameter DEPTH, default 256, maximum words per image; 1..2**ADDR_W.
REQ-004 SHALL have parameter BASE_ADDR, default 0, word address of the first image word.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1048576, inter-byte timeout in cycles; 0 disables the timeout.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port rx_dv_i, input, 1, one-cycle strobe marking a valid received UART byte.
REQ-009 SHALL have port rx_byte_i, input, 8, the received byte, sampled when rx_dv_i=1.
REQ-010 SHALL have port reload_i, input, 1, pulse that re-enters load mode from RUN.
REQ-011 SHALL have port we_o, input-side memory write strobe, output, 1.
REQ-012 SHALL have port addr_o, output, ADDR_W, memory word address.
REQ-013 SHALL have port wdata_o, output, DATA_W, memory write data.
REQ-014 SHALL have port core_rst_no, output, 1, active-low core reset; low while loading.
REQ-015 SHALL have port busy_o, output, 1, high in S_LEN after the first byte, in S_DATA and in S_CSUM.
REQ-016 SHALL have port done_o, output, 1, one-cycle pulse on a successful load.
REQ-017 SHALL have port err_o, output, 1, sticky error flag.

Function
REQ-018 SHALL implement the states S_LEN, S_DATA, S_CSUM and S_RUN.
REQ-019 S_LEN SHALL collect 2 bytes as little-endian word count N.
- After the 2nd byte: N==0 or N>DEPTH -> err_o=1, stay in S_LEN with the byte count cleared.
- Otherwise -> S_DATA, and err_o is cleared.
REQ-020 S_DATA SHALL assemble each word from DATA_W/8 bytes, little-endian, first byte in bits [7:0].
REQ-021 we_o SHALL pulse for exactly 1 cycle, in the cycle after the rx_dv_i that carries the last byte of a word.
- In that cycle: addr_o=BASE_ADDR+k (word index k from 0, mod 2**ADDR_W) and wdata_o holds the assembled word.
- addr_o and wdata_o SHALL hold their values until the next write.
REQ-022 After word N-1 is written the block SHALL enter S_CSUM; the running sum is the 8-bit sum mod 256 of all data bytes, length bytes excluded.
REQ-023 In S_CSUM, on the next byte:
- Byte equals the sum -> S_RUN; core_rst_no=1 and done_o=1 in the following cycle.
- Byte differs -> err_o=1, return to S_LEN, core_rst_no stays 0.
REQ-024 In S_RUN, rx bytes SHALL be ignored; reload_i=1 -> S_LEN with core_rst_no=0 in the next cycle.
REQ-025 Timeout counter SHALL clear on every rx_dv_i and count in busy states.
- Reaching TIMEOUT_CYC (when nonzero) -> err_o=1, return to S_LEN with byte/word counters and sum cleared, and no we_o.
REQ-026 Outside S_RUN, reload_i SHALL restart S_LEN, discarding any partial word.
- reload_i and rx_dv_i in the same cycle: reload_i wins and the byte is discarded.
REQ-027 Words already written before an abort SHALL NOT be rewritten or erased.
REQ-028 Counters SHALL be sized to DEPTH and TIMEOUT_CYC, with no overflow for legal parameters.

Reset
REQ-029 rst_i=1 at a clock edge SHALL force S_LEN, all counters and the sum to 0, we_o=0, done_o=0, err_o=0, busy_o=0, core_rst_no=0, addr_o=BASE_ADDR and wdata_o=0.
- This applies from any state, including mid-word and S_RUN.
REQ-030 The first rx byte accepted after reset SHALL be the cycle after rst_i deasserts.

Verification
REQ-031 Default parameters, bytes 02 00 | 11 22 33 44 | 55 66 77 88 | 64 -> two we_o pulses with (addr 0, 0x44332211) and (addr 1, 0x88776655), then done_o, core_rst_no=1.
REQ-032 Same image with checksum byte 00 -> err_o=1, core_rst_no=0, no done_o.
- A following correct frame loads and clears err_o.
REQ-033 Length bytes 00 00 and, separately, 01 01 (N=257>DEPTH) -> err_o=1, no we_o.
REQ-034 TIMEOUT_CYC=100, stop after 2 data bytes -> err_o at idle cycle 100, no we_o.
- A fresh frame then succeeds.
REQ-035 Reset mid-word, and reload_i in S_RUN with a simultaneous rx_dv_i -> S_LEN, core_rst_no=0, byte discarded.
REQ-036 DATA_W=16, BASE_ADDR=0x3FFF, N=2 -> addr_o values 0x3FFF then 0x0000, which is the wrap case.

Source files
------------

// File: rtl/iccm_loader.sv
// ---------------------------------------------------------------------------
// iccm_loader
//
// Purpose:
//   Boots an instruction memory from a UART byte stream. A frame is a 16-bit
//   little-endian word count N, then N words of DATA_W/8 little-endian bytes,
//   then one checksum byte. The checksum is the 8-bit sum of the data bytes.
//   The core is held in reset while loading and is released when a frame's
//   checksum matches. A reload pulse starts a new load at any time.
//
// Ports:
//   clk_i       - single clock, rising edge
//   rst_i       - synchronous active-high reset
//   rx_dv_i     - one-cycle strobe, rx_byte_i is valid
//   rx_byte_i   - received UART byte
//   reload_i    - restart loading (drops the core back into reset)
//   we_o        - one-cycle memory write strobe
//   addr_o      - memory word address, held between writes
//   wdata_o     - memory write data, held between writes
//   core_rst_no - active-low core reset, high only after a good load
//   busy_o      - a frame is in progress
//   done_o      - one-cycle pulse on a successful load
//   err_o       - sticky error flag, cleared by the next valid length
// ---------------------------------------------------------------------------
module iccm_loader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 14,
    parameter int DEPTH       = 256,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              reload_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int BPW   = DATA_W / 8;
    // The byte counter serves both the 2-byte length phase and the
    // per-word byte index, so it needs at least one bit.
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WC_W  = $clog2(DEPTH + 1);
    // The timer only ever holds values up to TIMEOUT_CYC-1.
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_e;

    state_e            state_q,    state_d;
    logic [BC_W-1:0]   byteCnt_q,  byteCnt_d;
    logic [7:0]        lenLo_q,    lenLo_d;
    logic [15:0]       len_q,      len_d;
    logic [WC_W-1:0]   wordCnt_q,  wordCnt_d;
    logic [7:0]        sum_q,      sum_d;
    logic [DATA_W-1:0] word_q,     word_d;
    logic [ADDR_W-1:0] nextAddr_q, nextAddr_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              we_q,       we_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [TMO_W-1:0]  tmo_q,      tmo_d;

    logic              busy;
    logic              tmoHit;
    logic [15:0]       lenWord;
    logic [DATA_W-1:0] asmWord;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_LEN;
            byteCnt_q  <= '0;
            lenLo_q    <= '0;
            len_q      <= '0;
            wordCnt_q  <= '0;
            sum_q      <= '0;
            word_q     <= '0;
            nextAddr_q <= BASE;
            addr_q     <= BASE;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            byteCnt_q  <= byteCnt_d;
            lenLo_q    <= lenLo_d;
            len_q      <= len_d;
            wordCnt_q  <= wordCnt_d;
            sum_q      <= sum_d;
            word_q     <= word_d;
            nextAddr_q <= nextAddr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        byteCnt_d  = byteCnt_q;
        lenLo_d    = lenLo_q;
        len_d      = len_q;
        wordCnt_d  = wordCnt_q;
        sum_d      = sum_q;
        word_d     = word_q;
        nextAddr_d = nextAddr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        tmo_d      = tmo_q;

        lenWord = {rx_byte_i, lenLo_q};

        // Drop the incoming byte into its lane; the lane index is the
        // byte count, so the first byte of a word lands in bits [7:0].
        asmWord = word_q;
        for (int b = 0; b < BPW; b++) begin
            if (byteCnt_q == BC_W'(b)) begin
                asmWord[8*b +: 8] = rx_byte_i;
            end
        end

        // Inter-byte timer: restarts on every byte, idles at zero
        // whenever no frame is in progress.
        tmoHit = (TIMEOUT_CYC != 0) && busy && !rx_dv_i &&
                 (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
        if (rx_dv_i || !busy) begin
            tmo_d = '0;
        end else if (TIMEOUT_CYC != 0) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (reload_i) begin
            // Reload beats a coincident byte, which is simply dropped.
            state_d   = S_LEN;
            byteCnt_d = '0;
            wordCnt_d = '0;
            sum_d     = '0;
            word_d    = '0;
            tmo_d     = '0;
        end else if (tmoHit) begin
            state_d   = S_LEN;
            err_d     = 1'b1;
            byteCnt_d = '0;
            wordCnt_d = '0;
            sum_d     = '0;
            word_d    = '0;
            tmo_d     = '0;
        end else if (rx_dv_i) begin
            unique case (state_q)
                S_LEN: begin
                    if (byteCnt_q == '0) begin
                        lenLo_d   = rx_byte_i;
                        byteCnt_d = BC_W'(1);
                    end else begin
                        byteCnt_d = '0;
                        if (lenWord == 16'd0 || {16'd0, lenWord} > 32'(DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            err_d      = 1'b0;
                            len_d      = lenWord;
                            state_d    = S_DATA;
                            wordCnt_d  = '0;
                            sum_d      = '0;
                            nextAddr_d = BASE;
                        end
                    end
                end
                S_DATA: begin
                    sum_d  = sum_q + rx_byte_i;
                    word_d = asmWord;
                    if (byteCnt_q == BC_W'(BPW - 1)) begin
                        byteCnt_d  = '0;
                        we_d       = 1'b1;
                        wdata_d    = asmWord;
                        addr_d     = nextAddr_q;
                        nextAddr_d = nextAddr_q + ADDR_W'(1);
                        if (32'(wordCnt_q) + 32'd1 == {16'd0, len_q}) begin
                            state_d   = S_CSUM;
                            wordCnt_d = '0;
                        end else begin
                            wordCnt_d = wordCnt_q + WC_W'(1);
                        end
                    end else begin
                        byteCnt_d = byteCnt_q + BC_W'(1);
                    end
                end
                S_CSUM: begin
                    if (rx_byte_i == sum_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LEN;
                        err_d   = 1'b1;
                    end
                    byteCnt_d = '0;
                    sum_d     = '0;
                end
                S_RUN: begin
                end
                default: begin
                    state_d = S_LEN;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy        = ((state_q == S_LEN) && (byteCnt_q != '0)) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
        busy_o      = busy;
        core_rst_no = (state_q == S_RUN);
        we_o        = we_q;
        addr_o      = addr_q;
        wdata_o     = wdata_q;
        done_o      = done_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_iccm_loader.sv
// ---------------------------------------------------------------------------
// tb_iccm_loader
//
// Directed bench for iccm_loader. dutA uses DATA_W=32 with a short timeout
// (100 cycles) so the timeout abort can be exercised; dutB uses DATA_W=16
// with BASE_ADDR=0x3FFF to show the address wrap. Writes and done pulses
// are logged on the falling edge and compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_iccm_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        rxDvA;
    logic [7:0]  rxByteA;
    logic        reloadA;
    logic        weA;
    logic [13:0] addrA;
    logic [31:0] wdataA;
    logic        coreRstNA;
    logic        busyA;
    logic        doneA;
    logic        errA;

    logic        rxDvB;
    logic [7:0]  rxByteB;
    logic        reloadB;
    logic        weB;
    logic [13:0] addrB;
    logic [15:0] wdataB;
    logic        coreRstNB;
    logic        busyB;
    logic        doneB;
    logic        errB;

    iccm_loader #(
        .TIMEOUT_CYC (100)
    ) dutA (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_dv_i     (rxDvA),
        .rx_byte_i   (rxByteA),
        .reload_i    (reloadA),
        .we_o        (weA),
        .addr_o      (addrA),
        .wdata_o     (wdataA),
        .core_rst_no (coreRstNA),
        .busy_o      (busyA),
        .done_o      (doneA),
        .err_o       (errA)
    );

    iccm_loader #(
        .DATA_W    (16),
        .BASE_ADDR ('h3FFF)
    ) dutB (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_dv_i     (rxDvB),
        .rx_byte_i   (rxByteB),
        .reload_i    (reloadB),
        .we_o        (weB),
        .addr_o      (addrB),
        .wdata_o     (wdataB),
        .core_rst_no (coreRstNB),
        .busy_o      (busyB),
        .done_o      (doneB),
        .err_o       (errB)
    );

    int totalCnt = 0;
    int badCnt   = 0;

    // Write/done logs, sampled away from the active edge
    logic [13:0] wrAddrA[$];
    logic [31:0] wrDataA[$];
    logic [13:0] wrAddrB[$];
    logic [15:0] wrDataB[$];
    int          doneCntA = 0;
    int          doneCntB = 0;

    always @(negedge clk) begin
        if (weA) begin
            wrAddrA.push_back(addrA);
            wrDataA.push_back(wdataA);
        end
        if (weB) begin
            wrAddrB.push_back(addrB);
            wrDataB.push_back(wdataB);
        end
        if (doneA) doneCntA++;
        if (doneB) doneCntB++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalCnt++;
        if (observed !== expected) begin
            badCnt++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // One byte: an idle cycle, then a one-cycle rx strobe.
    // Returns 1 ns after the edge that sampled the byte.
    task automatic applyStimulus(input bit selB, input logic [7:0] b);
        @(posedge clk); #1;
        if (selB) begin
            rxDvB   = 1'b1;
            rxByteB = b;
        end else begin
            rxDvA   = 1'b1;
            rxByteA = b;
        end
        @(posedge clk); #1;
        rxDvA = 1'b0;
        rxDvB = 1'b0;
    endtask

    task automatic pulseReloadA();
        @(posedge clk); #1;
        reloadA = 1'b1;
        @(posedge clk); #1;
        reloadA = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 02 00 | 11 22 33 44 | 55 66 77 88 | csum  (good checksum is 0x64)
    task automatic sendImageA(input logic [7:0] csum);
        applyStimulus(1'b0, 8'h02);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h22);
        applyStimulus(1'b0, 8'h33);
        applyStimulus(1'b0, 8'h44);
        applyStimulus(1'b0, 8'h55);
        applyStimulus(1'b0, 8'h66);
        applyStimulus(1'b0, 8'h77);
        applyStimulus(1'b0, 8'h88);
        applyStimulus(1'b0, csum);
    endtask

    int baseW;
    int baseD;

    initial begin
        rst     = 1'b1;
        rxDvA   = 1'b0;
        rxByteA = 8'h00;
        reloadA = 1'b0;
        rxDvB   = 1'b0;
        rxByteB = 8'h00;
        reloadB = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we",    weA,       0);
        checkOutput("rst_done",  doneA,     0);
        checkOutput("rst_err",   errA,      0);
        checkOutput("rst_busy",  busyA,     0);
        checkOutput("rst_core",  coreRstNA, 0);
        checkOutput("rst_addr",  addrA,     0);
        checkOutput("rst_wdata", wdataA,    0);
        checkOutput("rst_addrB", addrB,     14'h3FFF);
        rst = 1'b0;

        // Basic two-word load
        baseW = wrAddrA.size();
        baseD = doneCntA;
        applyStimulus(1'b0, 8'h02);
        checkOutput("busy_len1", busyA, 1);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h22);
        applyStimulus(1'b0, 8'h33);
        applyStimulus(1'b0, 8'h44);
        applyStimulus(1'b0, 8'h55);
        applyStimulus(1'b0, 8'h66);
        applyStimulus(1'b0, 8'h77);
        applyStimulus(1'b0, 8'h88);
        checkOutput("core_before_csum", coreRstNA, 0);
        applyStimulus(1'b0, 8'h64);
        checkOutput("done_pulse", doneA, 1);
        idle(2);
        checkOutput("load_wcount", wrAddrA.size() - baseW, 2);
        checkOutput("load_addr0",  wrAddrA[baseW],     0);
        checkOutput("load_data0",  wrDataA[baseW],     32'h44332211);
        checkOutput("load_addr1",  wrAddrA[baseW + 1], 1);
        checkOutput("load_data1",  wrDataA[baseW + 1], 32'h88776655);
        checkOutput("load_done",   doneCntA - baseD,   1);
        checkOutput("load_core",   coreRstNA, 1);
        checkOutput("load_busy",   busyA,     0);
        checkOutput("load_err",    errA,      0);
        checkOutput("hold_addr",   addrA,     1);
        checkOutput("hold_wdata",  wdataA,    32'h88776655);

        // RUN ignores bytes, reload re-enters loading
        applyStimulus(1'b0, 8'h05);
        checkOutput("run_ignore_busy", busyA, 0);
        pulseReloadA();
        checkOutput("reload_core", coreRstNA, 0);

        // Bad checksum, then a good frame clears the error
        baseD = doneCntA;
        sendImageA(8'h00);
        idle(2);
        checkOutput("badcs_err",  errA,      1);
        checkOutput("badcs_core", coreRstNA, 0);
        checkOutput("badcs_done", doneCntA - baseD, 0);
        sendImageA(8'h64);
        idle(2);
        checkOutput("goodcs_err",  errA,      0);
        checkOutput("goodcs_core", coreRstNA, 1);
        checkOutput("goodcs_done", doneCntA - baseD, 1);

        // Illegal lengths: 0 and 257
        pulseReloadA();
        baseW = wrAddrA.size();
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        idle(2);
        checkOutput("len0_err",  errA,  1);
        checkOutput("len0_busy", busyA, 0);
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h00);
        checkOutput("len1_clears_err", errA, 0);
        pulseReloadA();
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h01);
        idle(2);
        checkOutput("len257_err",  errA,  1);
        checkOutput("len257_busy", busyA, 0);
        checkOutput("badlen_nowe", wrAddrA.size() - baseW, 0);

        // Timeout after two data bytes
        baseW = wrAddrA.size();
        applyStimulus(1'b0, 8'h02);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h22);
        repeat (99) @(posedge clk);
        #1;
        checkOutput("tmo_early_err", errA, 0);
        @(posedge clk); #1;
        checkOutput("tmo_err",  errA,  1);
        checkOutput("tmo_busy", busyA, 0);
        checkOutput("tmo_nowe", wrAddrA.size() - baseW, 0);
        baseD = doneCntA;
        sendImageA(8'h64);
        idle(2);
        checkOutput("tmo_fresh_done",  doneCntA - baseD, 1);
        checkOutput("tmo_fresh_wc",    wrAddrA.size() - baseW, 2);
        checkOutput("tmo_fresh_data0", wrDataA[baseW], 32'h44332211);
        checkOutput("tmo_fresh_err",   errA, 0);

        // Reset mid-word
        pulseReloadA();
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'hAA);
        applyStimulus(1'b0, 8'hBB);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_rst_busy",  busyA,     0);
        checkOutput("mid_rst_core",  coreRstNA, 0);
        checkOutput("mid_rst_addr",  addrA,     0);
        checkOutput("mid_rst_wdata", wdataA,    0);
        rst = 1'b0;
        baseW = wrAddrA.size();
        baseD = doneCntA;
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h02);
        applyStimulus(1'b0, 8'h03);
        applyStimulus(1'b0, 8'h04);
        applyStimulus(1'b0, 8'h0A);
        idle(2);
        checkOutput("post_rst_wc",   wrAddrA.size() - baseW, 1);
        checkOutput("post_rst_data", wrDataA[baseW], 32'h04030201);
        checkOutput("post_rst_done", doneCntA - baseD, 1);

        // Reload in RUN with a coincident byte: byte must be dropped
        @(posedge clk); #1;
        reloadA = 1'b1;
        rxDvA   = 1'b1;
        rxByteA = 8'h02;
        @(posedge clk); #1;
        reloadA = 1'b0;
        rxDvA   = 1'b0;
        checkOutput("reload_dv_core", coreRstNA, 0);
        checkOutput("reload_dv_busy", busyA,     0);
        baseW = wrAddrA.size();
        baseD = doneCntA;
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h05);
        applyStimulus(1'b0, 8'h06);
        applyStimulus(1'b0, 8'h07);
        applyStimulus(1'b0, 8'h08);
        applyStimulus(1'b0, 8'h1A);
        idle(2);
        checkOutput("reload_dv_data", wrDataA[baseW], 32'h08070605);
        checkOutput("reload_dv_done", doneCntA - baseD, 1);
        checkOutput("reload_dv_err",  errA, 0);

        // 16-bit words, address wraps from 0x3FFF to 0x0000
        baseW = wrAddrB.size();
        baseD = doneCntB;
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b1, 8'h04);
        applyStimulus(1'b1, 8'h0A);
        idle(2);
        checkOutput("wrap_wc",    wrAddrB.size() - baseW, 2);
        checkOutput("wrap_addr0", wrAddrB[baseW],     14'h3FFF);
        checkOutput("wrap_data0", wrDataB[baseW],     16'h0201);
        checkOutput("wrap_addr1", wrAddrB[baseW + 1], 14'h0000);
        checkOutput("wrap_data1", wrDataB[baseW + 1], 16'h0403);
        checkOutput("wrap_done",  doneCntB - baseD,   1);
        checkOutput("wrap_core",  coreRstNB, 1);
        checkOutput("wrap_err",   errB, 0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
